// File: rtl/writeback_queue_pkg.sv
// Shared register-file constants for writeback_queue and its bypass lookup.
// Mirrors the regfile's address/data widths and the hardwired zero register.
package writeback_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wbq_bypass_lookup.sv
// Newest-match forwarding search over the pending-write entries.
// One instance per regfile read port; used only when WBQ_BYPASS_EN is defined.
module wbq_bypass_lookup
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_ADDR_W,
    parameter int DW    = REG_DATA_W,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0][AW-1:0] ent_addr,
    input  logic [DEPTH-1:0][DW-1:0] ent_data,
    input  logic [DEPTH-1:0]         ent_valid,
    input  logic [PW-1:0]            tail,
    input  logic [AW-1:0]            raddr,
    input  logic [DW-1:0]            fallback,
    output logic [DW-1:0]            rdata
);

    logic [PW-1:0] idx;

    // Walk oldest slot (at tail) to newest (tail-1); later hits override.
    always_comb begin
        rdata = fallback;
        idx   = tail;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail + PW'(i);
            if (ent_valid[idx] && (ent_addr[idx] == raddr)) begin
                rdata = ent_data[idx];
            end
        end
        if (raddr == AW'(REG_ZERO)) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Ordered write-back FIFO feeding the single regfile write port.
// Define WBQ_BYPASS_EN to forward pending writes to the decode read ports.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_ADDR_W,
    parameter int DW    = REG_DATA_W
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       ResultValid,
    output logic                       ResultReady,
    input  logic [AW-1:0]              ResultReg,
    input  logic [DW-1:0]              ResultData,
    input  logic                       WriteHold,
    output logic [AW-1:0]              WriteRegister,
    output logic [DW-1:0]              WriteData,
    output logic                       RegWrite,
    input  logic [AW-1:0]              ReadRegister1,
    input  logic [AW-1:0]              ReadRegister2,
    input  logic [DW-1:0]              RegfileData1,
    input  logic [DW-1:0]              RegfileData2,
    output logic [DW-1:0]              BypassData1,
    output logic [DW-1:0]              BypassData2,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic                     push;
    logic                     pop;
    logic                     nonempty;

    assign nonempty    = (count != '0);
    assign ResultReady = (count != CW'(DEPTH));
    // Writes to the zero register complete the handshake but are dropped.
    assign push        = ResultValid && ResultReady
                         && (ResultReg != AW'(REG_ZERO));
    assign pop         = nonempty && !WriteHold;

    assign RegWrite      = pop;
    assign WriteRegister = nonempty ? ent_addr[head] : '0;
    assign WriteData     = nonempty ? ent_data[head] : '0;
    assign Count         = count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            ent_addr[tail] <= ResultReg;
            ent_data[tail] <= ResultData;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] valid_nxt;

    always_comb begin
        valid_nxt = ent_valid;
        if (pop) begin
            valid_nxt[head] = 1'b0;
        end
        if (push) begin
            valid_nxt[tail] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ent_valid <= '0;
        end else begin
            ent_valid <= valid_nxt;
        end
    end

    wbq_bypass_lookup #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_byp1 (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .tail      (tail),
        .raddr     (ReadRegister1),
        .fallback  (RegfileData1),
        .rdata     (BypassData1)
    );

    wbq_bypass_lookup #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_byp2 (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .tail      (tail),
        .raddr     (ReadRegister2),
        .fallback  (RegfileData2),
        .rdata     (BypassData2)
    );
`else
    assign BypassData1 = (ReadRegister1 == AW'(REG_ZERO)) ? '0 : RegfileData1;
    assign BypassData2 = (ReadRegister2 == AW'(REG_ZERO)) ? '0 : RegfileData2;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed + random bench for writeback_queue against a queue-based model.
// Includes a behavioural regfile driven by the DUT's write port.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          ResultValid;
    logic          ResultReady;
    logic [AW-1:0] ResultReg;
    logic [DW-1:0] ResultData;
    logic          WriteHold;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [DW-1:0] RegfileData1;
    logic [DW-1:0] RegfileData2;
    logic [DW-1:0] BypassData1;
    logic [DW-1:0] BypassData2;
    logic [CW-1:0] Count;

    always #5 Clk = ~Clk;

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ResultValid   (ResultValid),
        .ResultReady   (ResultReady),
        .ResultReg     (ResultReg),
        .ResultData    (ResultData),
        .WriteHold     (WriteHold),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .RegfileData1  (RegfileData1),
        .RegfileData2  (RegfileData2),
        .BypassData1   (BypassData1),
        .BypassData2   (BypassData2),
        .Count         (Count)
    );

    function automatic logic [31:0] init_val(int i);
        return (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i));
    endfunction

    // Environment regfile, written only through the DUT write port.
    logic [DW-1:0] rf [32];
    logic          preload;

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (RegWrite) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    assign RegfileData1 = rf[ReadRegister1];
    assign RegfileData2 = rf[ReadRegister2];

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] mrf [32];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_byp(logic [AW-1:0] ra);
        if (ra == 0) return 32'h0;
`ifdef WBQ_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].r == ra) return q[i].d;
        end
`endif
        return mrf[ra];
    endfunction

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("count", 32'(Count), 32'(n));
        chk("ready", 32'(ResultReady), 32'(n != DEPTH));
        chk("regwrite", 32'(RegWrite), 32'((n != 0) && !WriteHold));
        chk("wreg", 32'(WriteRegister), (n != 0) ? 32'(q[0].r) : 32'h0);
        chk("wdata", WriteData, (n != 0) ? q[0].d : 32'h0);
        chk("byp1", BypassData1, exp_byp(ReadRegister1));
        chk("byp2", BypassData2, exp_byp(ReadRegister2));
    endtask

    // Check settled outputs, clock once, then apply the edge to the model.
    task automatic tick();
        logic          acc;
        logic          pp;
        logic [AW-1:0] pr;
        logic [DW-1:0] pd;
        ent_t          hd;
        ent_t          e;
        #2;
        check_outputs();
        acc = ResultValid && (q.size() != DEPTH);
        pp  = (q.size() != 0) && !WriteHold;
        pr  = ResultReg;
        pd  = ResultData;
        hd  = (q.size() != 0) ? q[0] : '0;
        @(posedge Clk);
        if (pp) begin
            mrf[hd.r] = hd.d;
            void'(q.pop_front());
        end
        if (acc && pr != 0) begin
            e.r = pr;
            e.d = pd;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(logic v, logic [AW-1:0] r, logic [DW-1:0] d,
                         logic h);
        ResultValid = v;
        ResultReg   = r;
        ResultData  = d;
        WriteHold   = h;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = init_val(i);
        preload       = 1'b1;
        Reset_n       = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        preload = 1'b0;
        #1;
        check_outputs();
        Reset_n = 1'b1;

        // Reset discards pending writes before they drain.
        drive(1'b1, 5'd5, 32'h55, 1'b1);
        tick();
        drive(1'b1, 5'd6, 32'h66, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        ReadRegister1 = 5'd5;
        Reset_n = 1'b0;
        q.delete();
        #1;
        chk("t1_regwrite", 32'(RegWrite), 32'h0);
        chk("t1_count", 32'(Count), 32'h0);
        chk("t1_ready", 32'(ResultReady), 32'h1);
        chk("t1_wreg", 32'(WriteRegister), 32'h0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        tick();
        chk("t1_rf5", rf[5], init_val(5));

        // Back-to-back enqueue with immediate drain.
        drive(1'b1, 5'd1, 32'h11, 1'b0);
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b0);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) tick();
        chk("t2_rf1", rf[1], 32'h11);
        chk("t2_rf2", rf[2], 32'h22);
        chk("t2_rf3", rf[3], 32'h33);
        chk("t2_count", 32'(Count), 32'h0);

        // Zero register writes are dropped.
        ReadRegister1 = 5'd0;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("t3_count", 32'(Count), 32'h0);
        chk("t3_byp1", BypassData1, 32'h0);

        // Fill to DEPTH under hold, fifth request waits.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 5'(k), 32'h400 + 32'(k), 1'b1);
            tick();
        end
        chk("t4_ready", 32'(ResultReady), 32'h0);
        chk("t4_count", 32'(Count), 32'h4);
        WriteHold = 1'b0;
        tick();
        chk("t4_ready_after_pop", 32'(ResultReady), 32'h1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        repeat (6) tick();
        chk("t4_rf5", rf[5], 32'h405);

        // Duplicate destination: newest pending value is forwarded.
        drive(1'b1, 5'd7, 32'hA, 1'b1);
        tick();
        drive(1'b1, 5'd7, 32'hB, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd8;
        #2;
`ifdef WBQ_BYPASS_EN
        chk("t5_byp1", BypassData1, 32'hB);
`else
        chk("t5_byp1", BypassData1, init_val(7));
`endif
        chk("t5_byp2", BypassData2, init_val(8));
        WriteHold = 1'b0;
        repeat (3) tick();
        chk("t5_rf7", rf[7], 32'hB);

        // Steady state at Count=2 with a push and pop every cycle.
        drive(1'b1, 5'd30, 32'h3030, 1'b1);
        tick();
        drive(1'b1, 5'd31, 32'h3131, 1'b1);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'((i % 31) + 1), $urandom, 1'b0);
            ReadRegister1 = 5'($urandom);
            ReadRegister2 = 5'((i % 31) + 1);
            tick();
            chk("t6_count", 32'(Count), 32'h2);
        end
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) tick();

        // Random traffic, including writes while full and to R0.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom), 5'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0));
            ReadRegister1 = 5'($urandom);
            ReadRegister2 = (i % 3 == 0) ? ResultReg : 5'($urandom);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        repeat (6) tick();
        chk("final_count", 32'(Count), 32'h0);
        for (int r = 1; r < 32; r++) begin
            chk($sformatf("final_rf%0d", r), rf[r], mrf[r]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
